data_bus_io: RTL

Data-side bus block for the single-cycle CPU: sits directly downstream of the CPU's data port and consumes its ALU address, store data and write enable. It returns read data combinationally in the same cycle and holds state on the rising clock edge. Inside it, the address space is decoded into a word-addressed data RAM and a small memory-mapped peripheral set: an LED register, synchronised switches, and a 32-bit down-counting timer with interrupt.

---
 rtl/cpu_bus_pkg.sv | 45 ++++
 rtl/timer32.sv | 87 ++++++++
 rtl/data_bus_io.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU data bus: address map,
// register bit positions and the address decoder.
package cpu_bus_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT  = 32'h0000_00FF;
  localparam logic [31:0] LED_ADDR   = 32'h0000_8000;
  localparam logic [31:0] SW_ADDR    = 32'h0000_8004;
  localparam logic [31:0] CTRL_ADDR  = 32'h0000_8008;
  localparam logic [31:0] LOAD_ADDR  = 32'h0000_800C;
  localparam logic [31:0] COUNT_ADDR = 32'h0000_8010;
  localparam logic [31:0] STAT_ADDR  = 32'h0000_8014;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_EXPIRED = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_CTRL,
    SEL_LOAD,
    SEL_COUNT,
    SEL_STAT
  } sel_e;

  // RAM_BASE is zero, so the RAM window is just a <= RAM_LIMIT.
  // Peripherals match on the word address; a[1:0] is ignored.
  function automatic sel_e decode(input logic [31:0] a);
    sel_e s;
    s = SEL_NONE;
    if (a <= RAM_LIMIT)                  s = SEL_RAM;
    else if (a[31:2] == LED_ADDR[31:2])   s = SEL_LED;
    else if (a[31:2] == SW_ADDR[31:2])    s = SEL_SW;
    else if (a[31:2] == CTRL_ADDR[31:2])  s = SEL_CTRL;
    else if (a[31:2] == LOAD_ADDR[31:2])  s = SEL_LOAD;
    else if (a[31:2] == COUNT_ADDR[31:2]) s = SEL_COUNT;
    else if (a[31:2] == STAT_ADDR[31:2])  s = SEL_STAT;
    return s;
  endfunction

endpackage

// File: rtl/timer32.sv
// 32-bit down-counting timer with prescaler, reload and irq.
// Ports: i_clk/i_clr, decoded write strobes, i_din, register views, o_irq.
module timer32
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_we_ctrl,
  input  logic        i_we_load,
  input  logic        i_we_stat,
  input  logic [31:0] i_din,
  output logic [31:0] o_ctrl,
  output logic [31:0] o_load,
  output logic [31:0] o_count,
  output logic [31:0] o_stat,
  output logic        o_irq
);

  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);

  logic [15:0] r_presc;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_en;
  logic        r_reload;
  logic        r_irq_en;
  logic        r_expired;

  logic w_tick;
  logic w_fire;
  logic w_zero;

  assign w_tick = r_en && (r_presc == PMAX);
  // A LOAD write swallows a coincident tick entirely.
  assign w_fire = w_tick && !i_we_load;
  assign w_zero = (r_count == 32'd0);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_presc   <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      if (i_we_load || !r_en || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + 16'd1;

      if (i_we_load)
        r_load <= i_din;

      if (i_we_load)
        r_count <= i_din;
      else if (w_fire && !w_zero)
        r_count <= r_count - 32'd1;
      else if (w_fire && r_reload)
        r_count <= r_load;

      if (i_we_ctrl) begin
        r_en     <= i_din[CTRL_EN];
        r_reload <= i_din[CTRL_RELOAD];
        r_irq_en <= i_din[CTRL_IRQ_EN];
      end else if (w_fire && w_zero && !r_reload) begin
        r_en <= 1'b0;
      end

      // Expiry set takes priority over write-1-clear.
      if (w_fire && w_zero)
        r_expired <= 1'b1;
      else if (i_we_stat && i_din[STAT_EXPIRED])
        r_expired <= 1'b0;
    end
  end

  assign o_ctrl  = {29'd0, r_irq_en, r_reload, r_en};
  assign o_load  = r_load;
  assign o_count = r_count;
  assign o_stat  = {31'd0, r_expired};
  assign o_irq   = r_expired & r_irq_en;

endmodule

// File: rtl/data_bus_io.sv
// CPU data-side bus: address decode, word RAM, LED, switch sync, timer.
// Ports: Clk/Clr, We/Addr/Date_in/Date_out, Sw in, Led and Irq out.
module data_bus_io
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [31:0] Date_in,
  output logic [31:0] Date_out,
  input  logic [15:0] Sw,
  output logic [15:0] Led,
  output logic        Irq
);

  sel_e w_sel;
  logic [RAM_AW-1:0] w_idx;

  logic [31:0] r_ram [2**RAM_AW];
  logic [15:0] r_led;
  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;

  logic [31:0] w_ctrl;
  logic [31:0] w_load;
  logic [31:0] w_count;
  logic [31:0] w_stat;
  logic        w_we;

  assign w_sel = decode(Addr);
  assign w_idx = Addr[RAM_AW+1:2];
  // Writes in a reset cycle must not land anywhere.
  assign w_we  = We && !Clr;

  always_ff @(posedge Clk) begin
    if (w_we && (w_sel == SEL_RAM))
      r_ram[w_idx] <= Date_in;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_led   <= '0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= Sw;
      r_sw_s2 <= r_sw_s1;
      if (We && (w_sel == SEL_LED))
        r_led <= Date_in[15:0];
    end
  end

  timer32 #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .i_clk     (Clk),
    .i_clr     (Clr),
    .i_we_ctrl (w_we && (w_sel == SEL_CTRL)),
    .i_we_load (w_we && (w_sel == SEL_LOAD)),
    .i_we_stat (w_we && (w_sel == SEL_STAT)),
    .i_din     (Date_in),
    .o_ctrl    (w_ctrl),
    .o_load    (w_load),
    .o_count   (w_count),
    .o_stat    (w_stat),
    .o_irq     (Irq)
  );

  always_comb begin
    Date_out = '0;
    unique case (w_sel)
      SEL_RAM:   Date_out = r_ram[w_idx];
      SEL_LED:   Date_out = {16'd0, r_led};
      SEL_SW:    Date_out = {16'd0, r_sw_s2};
      SEL_CTRL:  Date_out = w_ctrl;
      SEL_LOAD:  Date_out = w_load;
      SEL_COUNT: Date_out = w_count;
      SEL_STAT:  Date_out = w_stat;
      SEL_NONE:  Date_out = '0;
    endcase
  end

  assign Led = r_led;

endmodule
